// File: rtl/axis_width_conv.sv
// axis_width_conv: AXI4-Stream data-width converter with tkeep/tlast/tuser.
//   M_TDATA_WIDTH >  S_TDATA_WIDTH : packs narrow slave beats into wide words.
//   M_TDATA_WIDTH <  S_TDATA_WIDTH : splits wide slave words into narrow beats.
//   M_TDATA_WIDTH == S_TDATA_WIDTH : one-stage register slice (upsize path, RATIO=1).
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   s_axis_*          slave stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   m_axis_*          master stream, all outputs except s_axis_tready registered
// Lanes are little-endian: narrow lane k sits at wide bits [(k+1)*N-1 : k*N].
module axis_width_conv #(
    parameter int S_TDATA_WIDTH = 32,
    parameter int M_TDATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser
);
    localparam int SK    = S_TDATA_WIDTH / 8;
    localparam int MK    = M_TDATA_WIDTH / 8;
    localparam bit UP    = (M_TDATA_WIDTH >= S_TDATA_WIDTH);
    localparam int NW    = UP ? S_TDATA_WIDTH : M_TDATA_WIDTH;
    localparam int WW    = UP ? M_TDATA_WIDTH : S_TDATA_WIDTH;
    localparam int RATIO = WW / NW;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int NK    = NW / 8;

    generate
        if ((S_TDATA_WIDTH % 8) != 0 || (M_TDATA_WIDTH % 8) != 0 || (WW % NW) != 0) begin : g_bad_width
            $error("axis_width_conv: widths must be byte multiples and integer multiples of each other");
        end
    endgenerate

    // Master-side output register, shared by both conversion directions.
    logic                     m_valid_q, m_valid_d;
    logic [M_TDATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [MK-1:0]            m_keep_q, m_keep_d;
    logic                     m_last_q, m_last_d;
    logic                     m_user_q, m_user_d;
    logic                     s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;

    generate
        if (UP) begin : g_up
            logic [CW-1:0]            cnt_q, cnt_d;
            logic [M_TDATA_WIDTH-1:0] acc_data_q, acc_data_d;
            logic [MK-1:0]            acc_keep_q, acc_keep_d;
            logic                     acc_user_q, acc_user_d;
            logic                     completing, accept;
            logic [M_TDATA_WIDTH-1:0] word_data;
            logic [MK-1:0]            word_keep;

            always_comb begin
                completing = (cnt_q == CW'(RATIO - 1)) || s_axis_tlast;
                s_ready    = !rst && (!completing || !m_valid_q || m_axis_tready);
                accept     = s_axis_tvalid && s_ready;
                // Accumulator lanes above cnt are always zero (cleared on each
                // completion), so an early tlast word is zero-filled for free.
                word_data  = acc_data_q;
                word_data[cnt_q*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_axis_tdata;
                word_keep  = acc_keep_q;
                word_keep[cnt_q*SK +: SK] = s_axis_tkeep;

                cnt_d      = cnt_q;
                acc_data_d = acc_data_q;
                acc_keep_d = acc_keep_q;
                acc_user_d = acc_user_q;
                m_valid_d  = m_valid_q && !m_axis_tready;
                m_data_d   = m_data_q;
                m_keep_d   = m_keep_q;
                m_last_d   = m_last_q;
                m_user_d   = m_user_q;

                if (accept) begin
                    if (completing) begin
                        cnt_d      = '0;
                        acc_data_d = '0;
                        acc_keep_d = '0;
                        acc_user_d = 1'b0;
                        m_valid_d  = 1'b1;
                        m_data_d   = word_data;
                        m_keep_d   = word_keep;
                        m_last_d   = s_axis_tlast;
                        m_user_d   = acc_user_q | s_axis_tuser;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        acc_data_d = word_data;
                        acc_keep_d = word_keep;
                        acc_user_d = acc_user_q | s_axis_tuser;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q      <= '0;
                    acc_data_q <= '0;
                    acc_keep_q <= '0;
                    acc_user_q <= 1'b0;
                end else begin
                    cnt_q      <= cnt_d;
                    acc_data_q <= acc_data_d;
                    acc_keep_q <= acc_keep_d;
                    acc_user_q <= acc_user_d;
                end
            end
        end else begin : g_dn
            logic [S_TDATA_WIDTH-1:0] hd_data_q, hd_data_d;
            logic [SK-1:0]            hd_keep_q, hd_keep_d;
            logic                     hd_last_q, hd_last_d;
            logic                     hd_user_q, hd_user_d;
            logic                     held_q, held_d;
            logic [CW-1:0]            idx_q, idx_d;   // lane currently in the output register
            logic [CW-1:0]            fin_q, fin_d;   // last lane to emit for the held word
            logic                     xfer, fin_now, accept;
            logic [CW-1:0]            nidx, in_fin;

            // Non-tlast words emit every lane; tlast words stop at the highest
            // lane with any kept byte (lane 0 if none).
            function automatic logic [CW-1:0] final_lane(input logic [SK-1:0] keep, input logic last);
                logic [CW-1:0] f;
                f = last ? '0 : CW'(RATIO - 1);
                if (last) begin
                    for (int k = 0; k < RATIO; k++) begin
                        if (|keep[k*NK +: NK]) f = CW'(k);
                    end
                end
                return f;
            endfunction

            always_comb begin
                xfer    = m_valid_q && m_axis_tready;
                fin_now = xfer && (idx_q == fin_q);
                s_ready = !rst && (!held_q || fin_now);
                accept  = s_axis_tvalid && s_ready;
                nidx    = idx_q + 1'b1;
                in_fin  = final_lane(s_axis_tkeep, s_axis_tlast);

                hd_data_d = hd_data_q;
                hd_keep_d = hd_keep_q;
                hd_last_d = hd_last_q;
                hd_user_d = hd_user_q;
                held_d    = held_q;
                idx_d     = idx_q;
                fin_d     = fin_q;
                m_valid_d = m_valid_q && !m_axis_tready;
                m_data_d  = m_data_q;
                m_keep_d  = m_keep_q;
                m_last_d  = m_last_q;
                m_user_d  = m_user_q;

                if (fin_now) begin
                    held_d = 1'b0;
                end else if (xfer) begin
                    idx_d     = nidx;
                    m_valid_d = 1'b1;
                    m_data_d  = hd_data_q[nidx*M_TDATA_WIDTH +: M_TDATA_WIDTH];
                    m_keep_d  = hd_keep_q[nidx*MK +: MK];
                    m_last_d  = hd_last_q && (nidx == fin_q);
                    m_user_d  = hd_user_q;
                end

                // A new word goes straight to lane 0 of the output register so
                // consecutive words stream without a bubble.
                if (accept) begin
                    hd_data_d = s_axis_tdata;
                    hd_keep_d = s_axis_tkeep;
                    hd_last_d = s_axis_tlast;
                    hd_user_d = s_axis_tuser;
                    held_d    = 1'b1;
                    idx_d     = '0;
                    fin_d     = in_fin;
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata[M_TDATA_WIDTH-1:0];
                    m_keep_d  = s_axis_tkeep[MK-1:0];
                    m_last_d  = s_axis_tlast && (in_fin == '0);
                    m_user_d  = s_axis_tuser;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    hd_data_q <= '0;
                    hd_keep_q <= '0;
                    hd_last_q <= 1'b0;
                    hd_user_q <= 1'b0;
                    held_q    <= 1'b0;
                    idx_q     <= '0;
                    fin_q     <= '0;
                end else begin
                    hd_data_q <= hd_data_d;
                    hd_keep_q <= hd_keep_d;
                    hd_last_q <= hd_last_d;
                    hd_user_q <= hd_user_d;
                    held_q    <= held_d;
                    idx_q     <= idx_d;
                    fin_q     <= fin_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_axis_width_conv.sv
// Bench for axis_width_conv: a 32->128 upsizer and a 128->32 downsizer.
// Directed table and sequences drive each instance alone; the random phase
// chains them (up -> down) and compares against a packet-level model.
module tb_axis_width_conv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, chain;

    logic        us_valid, us_last, us_user;
    logic [31:0] us_data;
    logic [3:0]  us_keep;
    logic        up_s_ready, up_m_valid, up_m_last, up_m_user, up_m_ready, tb_up_mready;
    logic [127:0] up_m_data;
    logic [15:0]  up_m_keep;

    logic         ds_valid, ds_last, ds_user;
    logic [127:0] ds_data;
    logic [15:0]  ds_keep;
    logic         dn_s_valid, dn_s_last, dn_s_user, dn_s_ready;
    logic [127:0] dn_s_data;
    logic [15:0]  dn_s_keep;
    logic         dn_m_valid, dn_m_last, dn_m_user, dm_ready;
    logic [31:0]  dn_m_data;
    logic [3:0]   dn_m_keep;

    assign up_m_ready = chain ? dn_s_ready : tb_up_mready;
    assign dn_s_valid = chain ? up_m_valid : ds_valid;
    assign dn_s_data  = chain ? up_m_data  : ds_data;
    assign dn_s_keep  = chain ? up_m_keep  : ds_keep;
    assign dn_s_last  = chain ? up_m_last  : ds_last;
    assign dn_s_user  = chain ? up_m_user  : ds_user;

    axis_width_conv #(.S_TDATA_WIDTH(32), .M_TDATA_WIDTH(128)) u_up (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(us_valid), .s_axis_tready(up_s_ready), .s_axis_tdata(us_data),
        .s_axis_tkeep(us_keep), .s_axis_tlast(us_last), .s_axis_tuser(us_user),
        .m_axis_tvalid(up_m_valid), .m_axis_tready(up_m_ready), .m_axis_tdata(up_m_data),
        .m_axis_tkeep(up_m_keep), .m_axis_tlast(up_m_last), .m_axis_tuser(up_m_user));

    axis_width_conv #(.S_TDATA_WIDTH(128), .M_TDATA_WIDTH(32)) u_dn (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(dn_s_valid), .s_axis_tready(dn_s_ready), .s_axis_tdata(dn_s_data),
        .s_axis_tkeep(dn_s_keep), .s_axis_tlast(dn_s_last), .s_axis_tuser(dn_s_user),
        .m_axis_tvalid(dn_m_valid), .m_axis_tready(dm_ready), .m_axis_tdata(dn_m_data),
        .m_axis_tkeep(dn_m_keep), .m_axis_tlast(dn_m_last), .m_axis_tuser(dn_m_user));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_up(input string nm, input logic v, input logic [127:0] d,
                          input logic [15:0] k, input logic l, input logic u);
        chk({nm, "_valid"}, 160'(up_m_valid), 160'(v));
        if (v) begin
            chk({nm, "_data"}, 160'(up_m_data), 160'(d));
            chk({nm, "_keep"}, 160'(up_m_keep), 160'(k));
            chk({nm, "_last"}, 160'(up_m_last), 160'(l));
            chk({nm, "_user"}, 160'(up_m_user), 160'(u));
        end
    endtask

    task automatic chk_dn(input string nm, input logic v, input logic [31:0] d,
                          input logic [3:0] k, input logic l, input logic u);
        chk({nm, "_valid"}, 160'(dn_m_valid), 160'(v));
        if (v) begin
            chk({nm, "_data"}, 160'(dn_m_data), 160'(d));
            chk({nm, "_keep"}, 160'(dn_m_keep), 160'(k));
            chk({nm, "_last"}, 160'(dn_m_last), 160'(l));
            chk({nm, "_user"}, 160'(dn_m_user), 160'(u));
        end
    endtask

    typedef struct {
        logic v; logic [31:0] d; logic [3:0] k; logic l; logic u; logic mr;
        logic e_srdy; logic e_mv; logic [127:0] e_d; logic [15:0] e_k; logic e_l; logic e_u;
    } uvec_t;

    function automatic uvec_t mk(input logic v, input logic [31:0] d, input logic [3:0] k,
                                 input logic l, input logic u, input logic mr,
                                 input logic e_srdy, input logic e_mv, input logic [127:0] e_d,
                                 input logic [15:0] e_k, input logic e_l, input logic e_u);
        uvec_t r;
        r.v = v; r.d = d; r.k = k; r.l = l; r.u = u; r.mr = mr;
        r.e_srdy = e_srdy; r.e_mv = e_mv; r.e_d = e_d; r.e_k = e_k; r.e_l = e_l; r.e_u = e_u;
        return r;
    endfunction

    typedef struct { logic [31:0] d; logic [3:0] k; logic l; logic u; } beat_t;
    beat_t src_q[$];
    beat_t exp_q[$];

    localparam logic [127:0] W1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] W2 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] WZ = 128'hCAFEF00D_DEADBEEF_55AA55AA_12345678;
    localparam logic [127:0] WE = 128'h00000000_00000000_BBBBBBBB_AAAAAAAA;

    initial begin
        uvec_t tbl[10];
        rst = 1'b1; chain = 1'b0;
        us_valid = 1'b0; us_data = '0; us_keep = '0; us_last = 1'b0; us_user = 1'b0;
        ds_valid = 1'b0; ds_data = '0; ds_keep = '0; ds_last = 1'b0; ds_user = 1'b0;
        tb_up_mready = 1'b0; dm_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_up_srdy", 160'(up_s_ready), 160'(0));
        chk("rst_up_out", 160'({up_m_valid, up_m_data, up_m_keep, up_m_last, up_m_user}), 160'(0));
        chk("rst_dn_srdy", 160'(dn_s_ready), 160'(0));
        chk("rst_dn_out", 160'({dn_m_valid, dn_m_data, dn_m_keep, dn_m_last, dn_m_user}), 160'(0));
        rst = 1'b0;

        // ---------------- upsize table ----------------
        tbl[0] = mk(1'b1, 32'h03020100, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tbl[1] = mk(1'b1, 32'h07060504, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tbl[2] = mk(1'b1, 32'h0B0A0908, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 32'h0F0E0D0C, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tbl[4] = mk(1'b1, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, W1, 16'hFFFF, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 32'hBBBBBBBB, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, W1, 16'hFFFF, 1'b1, 1'b0);
        tbl[6] = mk(1'b1, 32'hBBBBBBBB, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, W1, 16'hFFFF, 1'b1, 1'b0);
        tbl[7] = mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, WE, 16'h003F, 1'b1, 1'b1);
        tbl[8] = mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, WE, 16'h003F, 1'b1, 1'b1);
        tbl[9] = mk(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            us_valid = tbl[i].v; us_data = tbl[i].d; us_keep = tbl[i].k;
            us_last = tbl[i].l; us_user = tbl[i].u; tb_up_mready = tbl[i].mr;
            #1;
            chk($sformatf("up_tbl%0d_srdy", i), 160'(up_s_ready), 160'(tbl[i].e_srdy));
            chk_up($sformatf("up_tbl%0d", i), tbl[i].e_mv, tbl[i].e_d, tbl[i].e_k, tbl[i].e_l, tbl[i].e_u);
        end

        // ---------------- downsize sequences ----------------
        @(negedge clk);
        ds_valid = 1'b1; ds_data = W1; ds_keep = 16'hFFFF; ds_last = 1'b1; ds_user = 1'b1; dm_ready = 1'b1;
        #1; chk("dn_idle_srdy", 160'(dn_s_ready), 160'(1));
        @(negedge clk);
        ds_data = W2; ds_keep = 16'h00FF; ds_last = 1'b1; ds_user = 1'b0;
        #1; chk_dn("dn_w1_l0", 1'b1, 32'h03020100, 4'hF, 1'b0, 1'b1);
        chk("dn_w1_l0_srdy", 160'(dn_s_ready), 160'(0));
        @(negedge clk); #1; chk_dn("dn_w1_l1", 1'b1, 32'h07060504, 4'hF, 1'b0, 1'b1);
        @(negedge clk); #1; chk_dn("dn_w1_l2", 1'b1, 32'h0B0A0908, 4'hF, 1'b0, 1'b1);
        @(negedge clk); #1; chk_dn("dn_w1_l3", 1'b1, 32'h0F0E0D0C, 4'hF, 1'b1, 1'b1);
        chk("dn_w1_l3_srdy", 160'(dn_s_ready), 160'(1));
        @(negedge clk);
        ds_data = WZ; ds_keep = 16'h0000; ds_last = 1'b1; ds_user = 1'b1;
        #1; chk_dn("dn_w2_l0", 1'b1, 32'h00000000, 4'hF, 1'b0, 1'b0);
        chk("dn_w2_l0_srdy", 160'(dn_s_ready), 160'(0));
        @(negedge clk); #1; chk_dn("dn_w2_l1", 1'b1, 32'h11111111, 4'hF, 1'b1, 1'b0);
        chk("dn_w2_l1_srdy", 160'(dn_s_ready), 160'(1));
        @(negedge clk);
        ds_valid = 1'b0;
        #1; chk_dn("dn_zero_keep", 1'b1, 32'h12345678, 4'h0, 1'b1, 1'b1);
        @(negedge clk); #1; chk_dn("dn_done", 1'b0, '0, '0, 1'b0, 1'b0);

        // ---------------- reset mid-packet (upsize, cnt=2) ----------------
        @(negedge clk);
        us_valid = 1'b1; us_data = 32'h99999999; us_keep = 4'hF; us_last = 1'b1; us_user = 1'b0;
        tb_up_mready = 1'b0;
        #1; chk("rstmid_srdy0", 160'(up_s_ready), 160'(1));
        @(negedge clk);
        us_data = 32'hA0A0A0A0; us_last = 1'b0;
        #1; chk("rstmid_full", 160'(up_m_valid), 160'(1));
        @(negedge clk);
        us_data = 32'hA1A1A1A1;
        @(negedge clk);
        us_valid = 1'b0; rst = 1'b1;
        #1; chk("rstmid_srdy_in_rst", 160'(up_s_ready), 160'(0));
        @(negedge clk); #1;
        chk("rstmid_mvalid", 160'(up_m_valid), 160'(0));
        chk("rstmid_srdy_next", 160'(up_s_ready), 160'(0));
        rst = 1'b0; tb_up_mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            us_valid = 1'b1; us_data = {4{8'(8'h11 * (i + 1))}}; us_keep = 4'hF; us_last = (i == 3);
        end
        @(negedge clk);
        us_valid = 1'b0; us_last = 1'b0;
        #1; chk_up("rstmid_next_pkt", 1'b1, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1, 1'b0);

        // ---------------- random chained up->down ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        chain = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            int len;
            beat_t pk[$];
            len = $urandom_range(1, 12);
            pk.delete();
            for (int j = 0; j < len; j++) begin
                beat_t b;
                b.d = $urandom;
                b.k = (j == len - 1) ? (4'hF >> $urandom_range(0, 3)) : 4'hF;
                b.l = (j == len - 1);
                b.u = ($urandom_range(0, 7) == 0);
                src_q.push_back(b);
                pk.push_back(b);
            end
            // Every narrow beat comes back 1:1; tuser is ORed over its 4-beat word.
            for (int j = 0; j < len; j++) begin
                beat_t e;
                logic uo;
                uo = 1'b0;
                for (int m = (j / 4) * 4; m < (j / 4) * 4 + 4 && m < len; m++) uo |= pk[m].u;
                e = pk[j];
                e.u = uo;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            int cyc;
            bit pres, st_up, st_dn;
            beat_t cur, e;
            logic [159:0] snap_up, snap_dn;
            cyc = 0; pres = 1'b0; st_up = 1'b0; st_dn = 1'b0;
            snap_up = '0; snap_dn = '0;
            cur = '{d: 32'h0, k: 4'h0, l: 1'b0, u: 1'b0};
            while (exp_q.size() > 0 && cyc < 80000) begin
                @(posedge clk); #1;
                if (!pres && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    cur = src_q.pop_front();
                    pres = 1'b1;
                end
                us_valid = pres; us_data = cur.d; us_keep = cur.k; us_last = cur.l; us_user = cur.u;
                dm_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (st_up) chk("stall_up", 160'({up_m_valid, up_m_data, up_m_keep, up_m_last, up_m_user}), snap_up);
                if (st_dn) chk("stall_dn", 160'({dn_m_valid, dn_m_data, dn_m_keep, dn_m_last, dn_m_user}), snap_dn);
                snap_up = 160'({up_m_valid, up_m_data, up_m_keep, up_m_last, up_m_user});
                snap_dn = 160'({dn_m_valid, dn_m_data, dn_m_keep, dn_m_last, dn_m_user});
                st_up = up_m_valid && !up_m_ready;
                st_dn = dn_m_valid && !dm_ready;
                if (dn_m_valid && dm_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL rand_extra_beat: got data %0h expected no beat", dn_m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rand_beat", 160'({dn_m_data, dn_m_keep, dn_m_last, dn_m_user}),
                            160'({e.d, e.k, e.l, e.u}));
                    end
                end
                if (pres && up_s_ready) pres = 1'b0;
                cyc++;
            end
            chk("rand_remaining", 160'(exp_q.size()), 160'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
